// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN stream merge schedulers: state encoding, counter sizing, output meta.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cnn_stream_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_B1    = 2'd1;
    localparam logic [1:0] ST_B2    = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        B1    = ST_B1,
        B2    = ST_B2,
        DRAIN = ST_DRAIN
    } sched_state_t;

    // Sideband travelling with each output pixel.
    typedef struct packed {
        logic sel;
        logic last;
    } out_meta_t;

    // Width for a counter spanning 0..n-1; never below one bit so D*D=1 stays legal.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/merge_sched_2i_frame_counter.sv
// Pixel/channel counter: flags the last pixel of a channel and the last channel of a branch.
// Latency: flags are combinational from the registered counts.
// Backpressure: counts only on inc; clear has priority.
module frame_counter #(
    parameter int PIX_N = 1,
    parameter int PW    = 1,
    parameter int CW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clear,
    input  logic [CW-1:0] ch_max,
    output logic          pix_last,
    output logic          ch_last
);

    localparam logic [PW-1:0] PIX_MAX = PW'(PIX_N - 1);

    logic [PW-1:0] pix_cnt;
    logic [CW-1:0] ch_cnt;

    assign pix_last = (pix_cnt == PIX_MAX);
    assign ch_last  = (ch_cnt == ch_max);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pix_cnt <= '0;
            ch_cnt  <= '0;
        end else if (inc) begin
            if (pix_last) begin
                pix_cnt <= '0;
                ch_cnt  <= ch_last ? '0 : ch_cnt + CW'(1);
            end else begin
                pix_cnt <= pix_cnt + PW'(1);
            end
        end
    end

endmodule

// File: rtl/merge_sched_2i.sv
// Two-input channel-concatenation scheduler: all C1 branch-1 channels, then all C2 branch-2 channels.
// Latency: 1 cycle from accept to pxl_out; full 1 pixel/cycle when ready_out stays high.
// Backpressure: ready_x only for the active branch and only when the output register is free or draining.
module merge_sched_2i
    import cnn_stream_pkg::*;
#(
    parameter int D          = 299,
    parameter int C1         = 1,
    parameter int C2         = 1,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  valid_in_1,
    input  logic [data_width-1:0] pxl_in_1,
    output logic                  ready_1,
    input  logic                  valid_in_2,
    input  logic [data_width-1:0] pxl_in_2,
    output logic                  ready_2,
    output logic [data_width-1:0] pxl_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  sel_out,
    output logic                  last_out,
    output logic                  busy,
    output logic                  done
);

    localparam int PIX_N = D * D;
    localparam int PW    = cnt_width(PIX_N);
    localparam int CMAX  = (C1 > C2) ? C1 : C2;
    localparam int CW    = cnt_width(CMAX + 1);

    if (C1 < 1 || C2 < 1) begin : g_bad_channels
        $error("merge_sched_2i: C1 and C2 must both be at least 1");
    end

    sched_state_t  state;
    out_meta_t     meta_q;
    logic          out_rdy;
    logic          acc_1;
    logic          acc_2;
    logic          fin_1;
    logic          fin_2;
    logic          pix_last;
    logic          ch_last;
    logic [CW-1:0] ch_max;

    // Output register can take a new pixel when empty or being emptied this cycle.
    assign out_rdy = !valid_out || ready_out;
    assign ready_1 = (state == B1) && out_rdy;
    assign ready_2 = (state == B2) && out_rdy;
    assign acc_1   = valid_in_1 && ready_1;
    assign acc_2   = valid_in_2 && ready_2;
    assign fin_1   = acc_1 && pix_last && ch_last;
    assign fin_2   = acc_2 && pix_last && ch_last;
    assign ch_max  = (state == B2) ? CW'(C2 - 1) : CW'(C1 - 1);

    assign sel_out  = meta_q.sel;
    assign last_out = meta_q.last;

    frame_counter #(
        .PIX_N (PIX_N),
        .PW    (PW),
        .CW    (CW)
    ) u_frame_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (acc_1 || acc_2),
        .clear    (state == IDLE),
        .ch_max   (ch_max),
        .pix_last (pix_last),
        .ch_last  (ch_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid_out <= 1'b0;
            pxl_out   <= '0;
            meta_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= B1;
                        busy  <= 1'b1;
                    end
                end
                B1: begin
                    if (fin_1) state <= B2;
                end
                B2: begin
                    if (fin_2) state <= DRAIN;
                end
                DRAIN: begin
                    if (out_rdy) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (acc_1 || acc_2) begin
                valid_out   <= 1'b1;
                pxl_out     <= acc_2 ? pxl_in_2 : pxl_in_1;
                meta_q.sel  <= acc_2;
                meta_q.last <= fin_2;
            end else if (ready_out) begin
                valid_out   <= 1'b0;
                meta_q.last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merge_sched_2i.sv
// Bench for merge_sched_2i: reset/startup vector table, then randomized operations against a count-based model.
// Two instances: C1=C2=1 and C1=2,C2=1, both with D=4.
module tb_merge_sched_2i;

    localparam int D = 4;
    localparam int P = D * D;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst   [2];
    logic         start [2];
    logic         v1    [2];
    logic         v2    [2];
    logic         ro    [2];
    logic [W-1:0] p1    [2];
    logic [W-1:0] p2    [2];
    logic [W-1:0] po    [2];
    logic         r1    [2];
    logic         r2    [2];
    logic         vo    [2];
    logic         so    [2];
    logic         lo    [2];
    logic         bz    [2];
    logic         dn    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        merge_sched_2i #(
            .D          (D),
            .C1         (g + 1),
            .C2         (1),
            .data_width (W)
        ) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .start      (start[g]),
            .valid_in_1 (v1[g]),
            .pxl_in_1   (p1[g]),
            .ready_1    (r1[g]),
            .valid_in_2 (v2[g]),
            .pxl_in_2   (p2[g]),
            .ready_2    (r2[g]),
            .pxl_out    (po[g]),
            .valid_out  (vo[g]),
            .ready_out  (ro[g]),
            .sel_out    (so[g]),
            .last_out   (lo[g]),
            .busy       (bz[g]),
            .done       (dn[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Reference model: an operation is "number of pixels accepted so far" against fixed channel quotas.
    int           c1p  [2];
    int           tot  [2];
    int           n    [2];
    bit           act  [2];
    bit           hv   [2];
    logic [W-1:0] hd   [2];
    bit           hs   [2];
    bit           hl   [2];
    bit           eb   [2];
    bit           ed   [2];
    int           idx1 [2];
    int           idx2 [2];
    int           ndone[2];

    typedef struct packed {
        bit           sel;
        bit           last;
        logic [W-1:0] pxl;
    } obs_t;
    obs_t q0[$];
    obs_t q1[$];

    typedef struct {
        bit rst, st, ro;
        bit e_r1, e_r2, e_vo, e_bz, e_dn;
        int e_px;
    } vec_t;
    vec_t tv[9];

    task automatic chk(input string nm, input int k, input longint act_v, input longint exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s[%0d] got %0d want %0d", nm, k, act_v, exp_v);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic drive_src();
        for (int k = 0; k < 2; k++) begin
            p1[k] = W'(idx1[k]);
            p2[k] = W'(100 + idx2[k]);
        end
    endtask

    task automatic tick();
        bit a1[2];
        bit a2[2];
        obs_t o;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit er1, er2;
            er1 = act[k] && n[k] < c1p[k] && (!hv[k] || ro[k]);
            er2 = act[k] && n[k] >= c1p[k] && n[k] < tot[k] && (!hv[k] || ro[k]);
            chk("ready_1", k, r1[k], er1);
            chk("ready_2", k, r2[k], er2);
            chk("valid_out", k, vo[k], hv[k]);
            chk("busy", k, bz[k], eb[k]);
            chk("done", k, dn[k], ed[k]);
            chk("pxl_out", k, po[k], hd[k]);
            if (hv[k]) begin
                chk("sel_out", k, so[k], hs[k]);
                chk("last_out", k, lo[k], hl[k]);
            end
            if (dn[k]) ndone[k]++;
            a1[k] = er1 && v1[k];
            a2[k] = er2 && v2[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                n[k] = 0; act[k] = 0; hv[k] = 0; hd[k] = '0;
                hs[k] = 0; hl[k] = 0; eb[k] = 0; ed[k] = 0;
            end else begin
                ed[k] = 0;
                if (hv[k] && ro[k]) begin
                    o.sel = hs[k]; o.last = hl[k]; o.pxl = hd[k];
                    if (k == 0) q0.push_back(o); else q1.push_back(o);
                end
                if (!act[k]) begin
                    if (start[k]) begin act[k] = 1; n[k] = 0; eb[k] = 1; end
                end else if (n[k] == tot[k] && (!hv[k] || ro[k])) begin
                    act[k] = 0; eb[k] = 0; ed[k] = 1;
                end
                if (a1[k] || a2[k]) begin
                    hd[k] = a1[k] ? p1[k] : p2[k];
                    hs[k] = a2[k];
                    hl[k] = (n[k] + 1 == tot[k]);
                    hv[k] = 1;
                    n[k]++;
                    if (a1[k]) idx1[k]++; else idx2[k]++;
                end else if (ro[k]) begin
                    hv[k] = 0;
                end
            end
        end
        @(negedge clk);
        drive_src();
    endtask

    // vmode: 0 both valid, 1 both random, 2 branch-1 random with branch-2 always valid.
    // romode: 0 always ready, 1 toggling, 2 random.
    task automatic run_op(input int k, input int vmode, input int romode, input bit spam, input int stop_after);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 0;
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        while (!seen && cyc < 3000) begin
            if (stop_after > 0 && qsize(k) >= stop_after) break;
            v1[k]    = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            v2[k]    = (vmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            ro[k]    = (romode == 0) ? 1'b1 : (romode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            start[k] = spam && ($urandom_range(0, 7) == 0);
            tick();
            cyc++;
            if (dn[k]) seen = 1;
        end
        start[k] = 1'b0;
        if (stop_after == 0) begin
            chk("done_seen", k, seen, 1);
            v1[k] = 1'b0; v2[k] = 1'b0; ro[k] = 1'b1;
            repeat (3) tick();
        end
    endtask

    task automatic prep(input int k);
        if (k == 0) q0.delete(); else q1.delete();
        idx1[k]  = 0;
        idx2[k]  = 0;
        ndone[k] = 0;
        drive_src();
    endtask

    task automatic check_frame(input int k);
        obs_t o;
        bit   esel;
        chk("out_count", k, qsize(k), tot[k]);
        for (int i = 0; i < qsize(k) && i < tot[k]; i++) begin
            o    = (k == 0) ? q0[i] : q1[i];
            esel = (i >= c1p[k]);
            chk("seq_sel", k, o.sel, esel);
            chk("seq_pxl", k, o.pxl, esel ? 100 + i - c1p[k] : i);
            chk("seq_last", k, o.last, i == tot[k] - 1);
        end
        chk("done_count", k, ndone[k], 1);
        prep(k);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; v1[k] = 1'b0; v2[k] = 1'b0; ro[k] = 1'b1;
            p1[k] = '0; p2[k] = '0;
            c1p[k] = (k + 1) * P;
            tot[k] = c1p[k] + P;
            n[k] = 0; act[k] = 0; hv[k] = 0; hd[k] = '0; hs[k] = 0; hl[k] = 0;
            eb[k] = 0; ed[k] = 0; idx1[k] = 0; idx2[k] = 0; ndone[k] = 0;
        end

        //           rst st ro   r1 r2 vo bz dn  px
        tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tv[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tv[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tv[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7};
        tv[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7};
        tv[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7};
        tv[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7};
        tv[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        v1[0] = 1'b1; p1[0] = W'(7);
        v2[0] = 1'b1; p2[0] = W'(200);
        for (int i = 0; i < 9; i++) begin
            rst[0]   = tv[i].rst;
            start[0] = tv[i].st;
            ro[0]    = tv[i].ro;
            @(posedge clk);
            #1;
            chk("tv_ready_1", i, r1[0], tv[i].e_r1);
            chk("tv_ready_2", i, r2[0], tv[i].e_r2);
            chk("tv_valid_out", i, vo[0], tv[i].e_vo);
            chk("tv_busy", i, bz[0], tv[i].e_bz);
            chk("tv_done", i, dn[0], tv[i].e_dn);
            chk("tv_pxl_out", i, po[0], tv[i].e_px);
            chk("tv_sel_out", i, so[0], 0);
            @(negedge clk);
        end

        start[0] = 1'b0; v1[0] = 1'b0; v2[0] = 1'b0; ro[0] = 1'b1;
        prep(0);
        prep(1);
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();

        run_op(0, 0, 0, 1'b0, 0);
        check_frame(0);

        run_op(0, 0, 1, 1'b0, 0);
        check_frame(0);

        run_op(1, 2, 2, 1'b0, 0);
        check_frame(1);

        run_op(0, 1, 0, 1'b0, 10);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        #1;
        chk("rst_valid_out", 0, vo[0], 0);
        chk("rst_busy", 0, bz[0], 0);
        chk("rst_ready_1", 0, r1[0], 0);
        prep(0);
        tick();
        run_op(0, 1, 2, 1'b0, 0);
        check_frame(0);

        run_op(0, 1, 2, 1'b1, 0);
        check_frame(0);

        run_op(1, 1, 2, 1'b1, 0);
        check_frame(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/merge_sched_2i.md
Name: merge_sched_2i

Overview:
Sequencing controller for the 2-input merge (channel-concatenation) stage of the CNN pixel-stream pipeline.
- Accepts two independent branch streams, each D×D pixels per channel.
- Emits one concatenated stream: all C1 channels of branch 1, then all C2 channels of branch 2.
- Back-pressures the idle branch via per-input ready signals.
- Sits between the upstream branch producers and the merge datapath/output writer, replacing free-running valid strobes with a counted, handshaked schedule.

Parameters:
- D, 299, feature-map side length; pixels per channel = D*D.
- C1, 1, channels delivered by branch 1 per merge operation.
- C2, 1, channels delivered by branch 2 per merge operation.
- data_width, 32, pixel word width.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins one merge operation; ignored while busy=1.
- valid_in_1  in  1  branch-1 pixel valid.
- pxl_in_1  in  data_width  branch-1 pixel.
- ready_1  out  1  branch-1 pixel accepted when valid_in_1 && ready_1.
- valid_in_2  in  1  branch-2 pixel valid.
- pxl_in_2  in  data_width  branch-2 pixel.
- ready_2  out  1  branch-2 pixel accepted when valid_in_2 && ready_2.
- pxl_out  out  data_width  concatenated output pixel (registered).
- valid_out  out  1  pxl_out valid.
- ready_out  in  1  downstream accepts when valid_out && ready_out.
- sel_out  out  1  branch of the current pxl_out: 0 = branch 1, 1 = branch 2.
- last_out  out  1  high with the final pixel of the whole operation.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the last output pixel is consumed.

Behaviour:
- Reset values: ready_1=0, ready_2=0, valid_out=0, pxl_out=0, sel_out=0, last_out=0, busy=0, done=0. State=IDLE; pix_cnt=0, ch_cnt=0.
- Counter widths:
  - pix_cnt: $clog2(D*D) bits, counts 0..D*D-1.
  - ch_cnt: $clog2(max(C1,C2)+1) bits.
  - Counters wrap only by explicit clear; no modulo arithmetic elsewhere.
- States:
  - IDLE: start=1 -> B1 next cycle; busy=1.
  - B1: accept branch-1 pixels.
    - Accepting the pixel with pix_cnt=D*D-1: pix_cnt clears, ch_cnt increments.
    - Accepting the pixel with pix_cnt=D*D-1 and ch_cnt=C1-1: counters clear, next state = B2.
  - B2: same rule using C2.
    - Final acceptance -> DRAIN.
  - DRAIN: wait until the output register is empty or being consumed this cycle (ready_out=1).
    - Then -> IDLE, done=1 for one cycle, busy=0 from that same cycle.
- Ready (combinational from registered state only; never depends on valid_in_x):
  - ready_1 = (state==B1) && (!valid_out || ready_out).
  - ready_2 = (state==B2) && (!valid_out || ready_out).
  - Never both high.
- Output register, 1-cycle latency:
  - An accepted pixel appears on pxl_out with valid_out=1 the next cycle.
  - sel_out = accepting branch; last_out=1 only for the final B2 pixel.
  - Output holds stable while valid_out && !ready_out.
  - If ready_out=1 and no new accept occurs, valid_out drops to 0 the next cycle.
  - Simultaneous consume and accept in one cycle gives a back-to-back transfer with no bubble: full throughput of 1 pixel/cycle when ready_out=1.
- Boundary behaviour:
  - Data on the non-selected branch is never consumed, and that branch's ready stays 0.
  - start asserted in any state other than IDLE has no effect.
  - start and reset asserted in the same cycle: reset wins.
  - Reset mid-operation: all state, counters, and outputs return to reset values next cycle; a partially sent frame is dropped.
  - C1=0 or C2=0 is illegal (elaboration-time check).
  - D*D=1: each pixel ends a channel.

Decomposition:
- Shared package cnn_stream_pkg holds:
  - State encoding IDLE/B1/B2/DRAIN as a 2-bit localparam set.
  - The pix_cnt width function (clog2) shared with the merge_3i/merge_4i schedulers.
- One natural sub-module: frame_counter.
  - Parameterised pixel/channel counter.
  - Inputs: inc, clear. Outputs: pix_last, ch_last.
  - Instantiated once and cleared on state change.

Test Plan:
1. D=4, C1=C2=1, both branches always valid (branch 1 = 0..15, branch 2 = 100..115), ready_out=1; start at cycle 2 -> 32 consecutive outputs 0..15 then 100..115, sel_out 0→1 at the 17th output, last_out on 115, done one cycle after 115 is accepted.
2. Same setup, ready_out toggles 1,0,1,0 -> no pixel lost or duplicated, pxl_out stable during each ready_out=0 cycle, total still 32.
3. D=4, C1=2, C2=1: branch 1 supplies 32 pixels -> ready_2 stays 0 until the 32nd branch-1 accept, output order is 32 branch-1 pixels then 16 branch-2 pixels.
4. Branch-2 valid high throughout B1 -> ready_2=0 throughout B1, and the first branch-2 pixel is delivered unchanged once B2 starts.
5. Reset at the 10th output -> next cycle valid_out=0, busy=0, ready_1=0; a new start restarts from branch-1 pixel 0.
6. start pulsed again while busy -> ignored; output count stays 32, and exactly one done pulse is produced.
